// File: rtl/i2c_byte_tx.sv
// i2c_byte_tx
// Sends one byte MSB first on SCL/SDA, then clocks a ninth (ACK) bit and
// reports whether the slave pulled SDA low. It takes over the bus after
// START has left SCL low. Each SCL phase lasts dbl_clock_divisor+1 cycles.
//
// Ports
//   clk                system clock
//   reset              synchronous, active-high reset
//   dbl_clock_divisor  half-period length minus one (latched on accept)
//   tx_valid/tx_ready  byte request handshake (ready only while idle)
//   tx_data            byte to send (latched on accept)
//   sda_in             synchronised SDA line
//   sda_out, scl_out   0 = drive low, 1 = release
//   busy               high from the cycle after accept through done
//   done               one-cycle pulse at the end of the ACK slot
//   ack                1 = slave acknowledged; holds until the next result
//
// state      | meaning
// k_idle     | waiting for a byte; bus lines hold their last value
// k_bit_low  | SCL low, SDA carries the current data bit
// k_bit_high | SCL high, data bit stable
// k_ack_low  | SCL low, SDA released for the slave
// k_ack_high | SCL high, ACK sampled on the last cycle
// k_done     | one-cycle completion pulse
module i2c_byte_tx (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] dbl_clock_divisor,
   input  logic        tx_valid,
   output logic        tx_ready,
   input  logic [7:0]  tx_data,
   input  logic        sda_in,
   output logic        sda_out,
   output logic        scl_out,
   output logic        busy,
   output logic        done,
   output logic        ack
);

   typedef enum logic [2:0] {
      k_idle,
      k_bit_low,
      k_bit_high,
      k_ack_low,
      k_ack_high,
      k_done
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] ctr_q, ctr_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [15:0] div_q, div_d;
   logic        ack_q, ack_d;
   logic        sda_q, sda_d;
   logic        scl_q, scl_d;
   logic        tc;

   always_comb begin
      state_d = state_q;
      ctr_d   = ctr_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      div_d   = div_q;
      ack_d   = ack_q;
      sda_d   = sda_q;
      scl_d   = scl_q;
      tc      = (ctr_q == div_q);

      // Shared phase timer for the four bus-driving states.
      if (state_q != k_idle && state_q != k_done) begin
         ctr_d = tc ? 16'd0 : ctr_q + 16'd1;
      end

      case (state_q)
         k_idle: begin
            if (tx_valid) begin
               shift_d = tx_data;
               div_d   = dbl_clock_divisor;
               bit_d   = 3'd7;
               ctr_d   = 16'd0;
               scl_d   = 1'b0;
               sda_d   = tx_data[7];
               state_d = k_bit_low;
            end
         end
         k_bit_low: begin
            if (tc) begin
               scl_d   = 1'b1;
               state_d = k_bit_high;
            end
         end
         k_bit_high: begin
            if (tc) begin
               scl_d = 1'b0;
               if (bit_q != 3'd0) begin
                  bit_d   = bit_q - 3'd1;
                  shift_d = {shift_q[6:0], 1'b0};
                  // Next bit goes out on the same edge that pulls SCL low.
                  sda_d   = shift_q[6];
                  state_d = k_bit_low;
               end else begin
                  sda_d   = 1'b1;
                  state_d = k_ack_low;
               end
            end
         end
         k_ack_low: begin
            if (tc) begin
               scl_d   = 1'b1;
               state_d = k_ack_high;
            end
         end
         k_ack_high: begin
            if (tc) begin
               ack_d   = ~sda_in;
               scl_d   = 1'b0;
               sda_d   = 1'b1;
               state_d = k_done;
            end
         end
         k_done: begin
            state_d = k_idle;
         end
         default: begin
            state_d = k_idle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= k_idle;
         ctr_q   <= 16'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         div_q   <= 16'd0;
         ack_q   <= 1'b0;
         sda_q   <= 1'b1;
         scl_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         div_q   <= div_d;
         ack_q   <= ack_d;
         sda_q   <= sda_d;
         scl_q   <= scl_d;
      end
   end

   // Lines are released while reset is held, not only after the edge.
   assign sda_out  = sda_q | reset;
   assign scl_out  = scl_q | reset;
   assign tx_ready = (state_q == k_idle) && !reset;
   assign busy     = (state_q != k_idle);
   assign done     = (state_q == k_done);
   assign ack      = ack_q;

endmodule

// File: tb/tb_i2c_byte_tx.sv
// Directed bench for i2c_byte_tx. Expected SDA bits and ACK results are
// queued when a byte is issued; a bus monitor pops bits at each SCL rise
// and checks phase lengths and SDA stability while SCL is high.
module tb_i2c_byte_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] dbl_clock_divisor;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  tx_data;
   logic        sda_in;
   logic        sda_out;
   logic        scl_out;
   logic        busy;
   logic        done;
   logic        ack;

   int   n_assert = 0;
   int   n_fail   = 0;
   logic bit_q[$];
   logic ack_q[$];
   int   exp_phase = 1;

   i2c_byte_tx dut (
      .clk               (clk),
      .reset             (reset),
      .dbl_clock_divisor (dbl_clock_divisor),
      .tx_valid          (tx_valid),
      .tx_ready          (tx_ready),
      .tx_data           (tx_data),
      .sda_in            (sda_in),
      .sda_out           (sda_out),
      .scl_out           (scl_out),
      .busy              (busy),
      .done              (done),
      .ack               (ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bus monitor
   int   hi_run = 0;
   int   lo_run = 0;
   logic prev_scl = 1'b1;
   logic prev_sda = 1'b1;
   logic prev_busy = 1'b0;

   always @(negedge clk) begin
      if (!busy || reset) begin
         hi_run = 0;
         lo_run = 0;
      end else if (scl_out) begin
         if (!prev_scl && prev_busy) begin
            chk("scl_low_len", lo_run, exp_phase);
            if (bit_q.size() > 0) chk("sda_bit", sda_out, bit_q.pop_front());
            else chk("extra_bit", bit_q.size(), 1);
         end
         if (prev_scl && prev_busy) chk("sda_stable_scl_high", sda_out, prev_sda);
         hi_run++;
         lo_run = 0;
      end else begin
         if (prev_scl && prev_busy && hi_run != 0) chk("scl_high_len", hi_run, exp_phase);
         lo_run++;
         hi_run = 0;
      end
      prev_scl  = scl_out;
      prev_sda  = sda_out;
      prev_busy = busy && !reset;
   end

   task automatic push_byte(input logic [7:0] data, input logic exp_ack);
      for (int i = 7; i >= 0; i--) bit_q.push_back(data[i]);
      bit_q.push_back(1'b1);
      ack_q.push_back(exp_ack);
   endtask

   // 0: released, 1: held low, 2: low except last ACK-high cycle,
   // 3: low only on last ACK-high cycle
   function automatic logic sda_drive(input int mode, input int n, input int last);
      case (mode)
         0:       return 1'b1;
         1:       return 1'b0;
         2:       return (n == last);
         default: return (n != last);
      endcase
   endfunction

   // Ends at the sample point of cycle 1 after the accept edge.
   task automatic start_byte(input logic [7:0] data, input logic [15:0] d,
                             input logic exp_ack, input logic hold);
      @(negedge clk);
      chk("ready_before_accept", tx_ready, 1);
      tx_data           = data;
      dbl_clock_divisor = d;
      tx_valid          = 1'b1;
      push_byte(data, exp_ack);
      exp_phase = d + 1;
      @(negedge clk);
      if (!hold) tx_valid = 1'b0;
      chk("busy_after_accept", busy, 1);
      chk("scl_after_accept", scl_out, 0);
      chk("sda_first_bit", sda_out, data[7]);
   endtask

   // n0 = cycle number (after accept) of the current sample point.
   task automatic wait_done(input logic [15:0] d, input int mode, input int n0);
      int   last;
      int   lim;
      int   n;
      logic exp_ack;
      last   = 18 * (d + 1);
      lim    = last + 20;
      n      = n0;
      sda_in = sda_drive(mode, n, last);
      while (done !== 1'b1 && n < lim) begin
         @(negedge clk);
         n++;
         sda_in = sda_drive(mode, n, last);
      end
      chk("done_cycle", n, last + 1);
      exp_ack = (ack_q.size() > 0) ? ack_q.pop_front() : 1'bx;
      chk("ack_at_done", ack, exp_ack);
      chk("bits_consumed", bit_q.size(), 0);
      sda_in = 1'b1;
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_ready", tx_ready, 1);
      chk("idle_scl_low", scl_out, 0);
      chk("idle_sda_released", sda_out, 1);
      chk("idle_not_busy", busy, 0);
      chk("ack_held", ack, exp_ack);
   endtask

   initial begin
      int seen;
      reset             = 1'b1;
      tx_valid          = 1'b0;
      tx_data           = 8'h00;
      dbl_clock_divisor = 16'd0;
      sda_in            = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_sda", sda_out, 1);
      chk("rst_scl", scl_out, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ack", ack, 0);
      chk("rst_ready_low", tx_ready, 0);
      reset = 1'b0;
      #1;
      chk("ready_after_rst", tx_ready, 1);

      // A5, D=3, slave ACKs
      start_byte(8'hA5, 16'd3, 1'b1, 1'b0);
      wait_done(16'd3, 1, 1);

      // 00, D=3, no ACK
      start_byte(8'h00, 16'd3, 1'b0, 1'b0);
      wait_done(16'd3, 0, 1);

      // FF, D=0, back to back with tx_valid held
      start_byte(8'hFF, 16'd0, 1'b1, 1'b1);
      wait_done(16'd0, 1, 1);
      push_byte(8'hFF, 1'b1);
      @(negedge clk);
      tx_valid = 1'b0;
      chk("b2b_second_accept", busy, 1);
      chk("b2b_scl", scl_out, 0);
      chk("b2b_sda", sda_out, 1);
      wait_done(16'd0, 1, 1);

      // 3C, D=2, inputs disturbed mid-byte
      start_byte(8'h3C, 16'd2, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      tx_data           = 8'hFF;
      dbl_clock_divisor = 16'd7;
      wait_done(16'd2, 0, 6);

      // Reset 20 cycles into a D=3 byte
      start_byte(8'hA5, 16'd3, 1'b1, 1'b0);
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_sda", sda_out, 1);
      chk("midrst_scl", scl_out, 1);
      chk("midrst_ready", tx_ready, 1);
      chk("midrst_ack", ack, 0);
      chk("midrst_busy", busy, 0);
      bit_q.delete();
      ack_q.delete();
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("midrst_no_done", seen, 0);

      // Reset wins over a simultaneous request
      @(negedge clk);
      reset    = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'h81;
      @(negedge clk);
      chk("rst_prio_busy", busy, 0);
      chk("rst_prio_ready", tx_ready, 0);
      tx_valid = 1'b0;
      reset    = 1'b0;
      #1;
      chk("rst_prio_ready_after", tx_ready, 1);

      // ACK sampled only on the final ACK-high cycle, D=4
      start_byte(8'h5A, 16'd4, 1'b0, 1'b0);
      wait_done(16'd4, 2, 1);
      start_byte(8'hC3, 16'd4, 1'b1, 1'b0);
      wait_done(16'd4, 3, 1);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
